simon_input_conditioner: RTL

Front-end stage of the Simon game, sitting between the raw board inputs and the game core (datapath and control). It synchronizes the asynchronous push button and slide switches to `sysclk` and debounces the button with a counter-based state machine. It produces a clean button level plus single-cycle press and release strobes. It also snapshots the pattern switches at the moment a press is accepted, so the core sees a stable guess.

---
 rtl/simon_pkg.sv | 19 +
 rtl/simon_sync2.sv | 23 ++
 rtl/simon_input_conditioner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: button FSM states and board-level constants.
package simon_pkg;

    localparam int unsigned SIMON_DEBOUNCE_DEFAULT = 500000;
    localparam int unsigned SIMON_PATTERN_W        = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        DISARMING = 2'd3
    } btn_state_t;

    // Button counts as held once a press is accepted and until its release is accepted.
    function automatic logic btn_held(input btn_state_t s);
        return (s == PRESSED) || (s == DISARMING);
    endfunction

endpackage

// File: rtl/simon_sync2.sv
// Parameterized-width two-flop synchronizer; nothing sits between the two flop stages.
module simon_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         sysclk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/simon_input_conditioner.sv
// Synchronizes the raw board inputs, debounces the push button and snapshots the
// pattern switches on each accepted press for the game core.
module simon_input_conditioner
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SIMON_DEBOUNCE_DEFAULT
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       noisy_btn,
    input  logic [SIMON_PATTERN_W-1:0] pattern_sw,
    input  logic                       level_sw,
    output logic                       clean_btn,
    output logic                       press_pulse,
    output logic                       release_pulse,
    output logic [SIMON_PATTERN_W-1:0] pattern_q,
    output logic                       level_q
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SYNC_W = SIMON_PATTERN_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_W-1:0]          sync_d;
    logic [SYNC_W-1:0]          sync_q;
    logic                       btn_s;
    logic                       lvl_s;
    logic [SIMON_PATTERN_W-1:0] pat_s;

    btn_state_t                 state;
    btn_state_t                 state_nxt;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_nxt;
    logic                       clean_nxt;
    logic                       press_nxt;
    logic                       release_nxt;
    logic [SIMON_PATTERN_W-1:0] pattern_nxt;
    logic                       level_nxt;

    // All asynchronous board inputs share one synchronizer bank.
    assign sync_d = {noisy_btn, level_sw, pattern_sw};

    simon_sync2 #(
        .W (SYNC_W)
    ) u_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .d      (sync_d),
        .q      (sync_q)
    );

    assign btn_s = sync_q[SYNC_W-1];
    assign lvl_s = sync_q[SIMON_PATTERN_W];
    assign pat_s = sync_q[SIMON_PATTERN_W-1:0];

    // State, counter and registered outputs.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            clean_btn     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            pattern_q     <= '0;
            level_q       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            clean_btn     <= clean_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            pattern_q     <= pattern_nxt;
            level_q       <= level_nxt;
        end
    end

    // Debounce FSM: an edge is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        pattern_nxt = pattern_q;
        level_nxt   = level_q;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = ARMING;
                    cnt_nxt   = '0;
                end else begin
                    level_nxt = lvl_s;
                end
            end
            ARMING: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = PRESSED;
                    cnt_nxt     = '0;
                    press_nxt   = 1'b1;
                    pattern_nxt = pat_s;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = DISARMING;
                    cnt_nxt   = '0;
                end
            end
            DISARMING: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        clean_nxt = btn_held(state_nxt);
    end

endmodule
